hilo_pipe: RTL and testbench
============================

# hilo_pipe

Staged HI/LO register block for the MIPS core. It sits directly downstream of the execute-stage ALU and captures the ALU's hi/lo write requests (MULT/MULTU/DIV/DIVU/MTHI/MTLO). It carries them through MEM and WB pipeline slots and commits them to architectural HI/LO at writeback. It also returns forwarded HI/LO read values to the execute stage for MFHI/MFLO, which the ALU consumes on its second operand. Pending writes can be squashed by a MEM-stage flush.

## Interface
- No parameters; widths come from the shared `word_t` (32 bits).
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  pipeline freeze; holds both slots and suppresses commit.
- `flush`  in  1  MEM-stage exception; squashes the MEM slot and blocks capture.
- `ex_valid`  in  1  execute stage holds a real instruction this cycle.
- `ex_hi_write`  in  1  ALU hi write enable.
- `ex_lo_write`  in  1  ALU lo write enable.
- `ex_hi_data`  in  32  ALU hi result.
- `ex_lo_data`  in  32  ALU lo result.
- `hi_rd`  out  32  forwarded HI value, combinational, for MFHI in EX.
- `lo_rd`  out  32  forwarded LO value, combinational, for MFLO in EX.
- `hi_arch`  out  32  committed HI register.
- `lo_arch`  out  32  committed LO register.

## Operation
- **Slots.** There are two slots, M and W. Each slot holds `hw`, `lw`, `hd` and `ld`. Slot enables already fold in validity; an empty slot has `hw=lw=0`.
- **Capture.** EX presents `{ex_hi_write&ex_valid, ex_lo_write&ex_valid, ex_hi_data, ex_lo_data}`.
- **Normal cycle** (`!stall && !flush`):
  - HI commits from W when W.hw is set: `hi_arch<=W.hd`.
  - LO commits from W when W.lw is set: `lo_arch<=W.ld`.
  - `W<=M`, then `M<=EX capture`.
- **Stall** (`stall && !flush`):
  - M, W, `hi_arch` and `lo_arch` all hold.
  - No commit occurs and the EX capture is dropped. The upstream stage holds its instruction, so it is presented again.
- **Flush**, which overrides stall:
  - W commits as in a normal cycle, because it is older than the excepting instruction.
  - W is emptied, M is emptied, and the EX capture is discarded.
- **HI forwarding priority** for `hi_rd`: M.hd if M.hw, else W.hd if W.hw, else `hi_arch`.
- **LO forwarding** (`lo_rd`): the same priority using the lo fields. HI and LO are resolved independently. For example, M writes only HI (MTHI) while W writes LO: then `lo_rd` comes from W.
- **No self-forwarding.** The EX capture is never forwarded to `hi_rd`/`lo_rd`.
- **Data width.** Data is passed through unmodified; the block does no arithmetic.
- **Disabled fields.** Write-enable-false data fields are don't-care. The bench checks only enabled effects.

## Timing
- **Reset values.** `hi_arch=lo_arch=0`, both slots empty, so `hi_rd=lo_rd=0`. Reset is asynchronous and takes effect mid-operation: all pending writes are lost.
- **Commit latency.** A write captured at edge N, with no stalls, is in M during cycle N..N+1. It is in W during N+1..N+2 and visible on `hi_arch`/`lo_arch` after edge N+2. Each stall cycle adds one cycle.
- **Forward latency.** After capture edge N, the value appears on `hi_rd` in the next cycle. An MFHI immediately following a MULT reads the MULT result.
- **Back-to-back writes.** These resolve youngest-first via the M>W>arch priority.
- **Stall in the same cycle as a W-slot write.** The commit is deferred, not duplicated.
- **Flush with W valid and M valid.** W is committed and M is lost. After the edge, `hi_rd`/`lo_rd` equal the new arch values.

## Structure
- Add a `hilo_slot_t` packed struct (`hw`, `lw`, `hd`, `ld`) to the shared defs package alongside `word_t`.
- Everything else is local.
- One sub-module is natural: `hilo_fwd_mux`, a combinational 3-source priority select instantiated once for HI and once for LO.

## Test plan
- **Reset, then idle.** Assert `reset` asynchronously mid-cycle -> `hi_rd`, `lo_rd`, `hi_arch` and `lo_arch` read 0 immediately; with no writes they stay 0.
- **MULT write.** Capture `hi=0x00000001`, `lo=0xFFFFFFFE` with both enables -> `hi_rd=1` in the next cycle; `hi_arch=1` and `lo_arch=0xFFFFFFFE` two edges after capture.
- **Split HI/LO sources.** Write MTLO `0x11`, then MTHI `0x22` back-to-back -> one cycle later `hi_rd=0x22` (from M) and `lo_rd=0x11` (from W).
- **Stall.** Capture a write, then hold `stall` for 3 cycles -> `hi_arch` is unchanged throughout and commits 2 non-stall edges after capture; no duplicate commit.
- **Flush.** W holds `hi=0xAA` and M holds `hi=0xBB`; pulse `flush` -> `hi_arch=0xAA`, `hi_rd=0xAA`, and `0xBB` never commits.
- **Flush during stall.** Assert `flush` and `stall` together with an EX write `0xCC` -> `0xCC` is not captured and W commits.

Source files
------------

// File: rtl/hilo_pipe_pkg.sv
// Shared definitions for the HI/LO staging block: the machine word and the
// per-slot pending-write record carried through the MEM and WB slots.
package hilo_pipe_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // One pending HI/LO write. Enables already include instruction validity,
  // so an empty slot is simply hw=lw=0 with don't-care data.
  typedef struct packed {
    logic  hw;
    logic  lw;
    word_t hd;
    word_t ld;
  } hilo_slot_t;

  localparam hilo_slot_t SLOT_EMPTY = '{hw: 1'b0, lw: 1'b0, hd: '0, ld: '0};

endpackage

// File: rtl/hilo_fwd_mux.sv
// Three-source priority select used to forward one of HI or LO to EX:
// the youngest pending write (M) wins, then W, then the committed value.
module hilo_fwd_mux
  import hilo_pipe_pkg::*;
(
  input  logic  i_m_en,
  input  word_t i_m_data,
  input  logic  i_w_en,
  input  word_t i_w_data,
  input  word_t i_arch,
  output word_t o_data
);

  // Youngest-first priority: M over W over architectural state.
  always_comb begin
    o_data = i_arch;
    if (i_m_en) begin
      o_data = i_m_data;
    end else if (i_w_en) begin
      o_data = i_w_data;
    end
  end

endmodule

// File: rtl/hilo_pipe.sv
// Staged HI/LO register block. Captures ALU hi/lo write requests from EX,
// carries them through the M and W slots, commits them to HI/LO at
// writeback, and forwards the youngest pending value back to EX.
module hilo_pipe
  import hilo_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  flush,
  input  logic  ex_valid,
  input  logic  ex_hi_write,
  input  logic  ex_lo_write,
  input  word_t ex_hi_data,
  input  word_t ex_lo_data,
  output word_t hi_rd,
  output word_t lo_rd,
  output word_t hi_arch,
  output word_t lo_arch
);

  hilo_slot_t r_m;
  hilo_slot_t r_w;
  word_t      r_hi_arch;
  word_t      r_lo_arch;
  hilo_slot_t w_cap;
  logic       w_advance;

  // EX request with validity folded into the enables.
  assign w_cap = '{hw: ex_hi_write & ex_valid,
                   lw: ex_lo_write & ex_valid,
                   hd: ex_hi_data,
                   ld: ex_lo_data};

  // W commits on a normal cycle and on a flush (W is older than the
  // excepting instruction); only a stall without flush defers it.
  assign w_advance = flush | ~stall;

  // Architectural HI/LO: commit the W slot when the pipe advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi_arch <= '0;
      r_lo_arch <= '0;
    end else if (w_advance) begin
      if (r_w.hw) r_hi_arch <= r_w.hd;
      if (r_w.lw) r_lo_arch <= r_w.ld;
    end
  end

  // Slot shift: flush empties both slots and drops the capture; stall
  // holds both slots (EX re-presents its instruction later).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m <= SLOT_EMPTY;
      r_w <= SLOT_EMPTY;
    end else if (flush) begin
      r_m <= SLOT_EMPTY;
      r_w <= SLOT_EMPTY;
    end else if (!stall) begin
      r_w <= r_m;
      r_m <= w_cap;
    end
  end

  // HI and LO forwarding resolve independently; EX capture is never
  // forwarded to itself.
  hilo_fwd_mux u_fwd_hi (
    .i_m_en   (r_m.hw),
    .i_m_data (r_m.hd),
    .i_w_en   (r_w.hw),
    .i_w_data (r_w.hd),
    .i_arch   (r_hi_arch),
    .o_data   (hi_rd)
  );

  hilo_fwd_mux u_fwd_lo (
    .i_m_en   (r_m.lw),
    .i_m_data (r_m.ld),
    .i_w_en   (r_w.lw),
    .i_w_data (r_w.ld),
    .i_arch   (r_lo_arch),
    .o_data   (lo_rd)
  );

  assign hi_arch = r_hi_arch;
  assign lo_arch = r_lo_arch;

endmodule

// File: tb/tb_hilo_pipe.sv
// Bench for hilo_pipe: directed vector table, randomized run against a
// pending-write reference model, and an asynchronous mid-cycle reset.
module tb_hilo_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_hi_write = 1'b0;
  logic        ex_lo_write = 1'b0;
  logic [31:0] ex_hi_data = '0;
  logic [31:0] ex_lo_data = '0;
  logic [31:0] hi_rd, lo_rd, hi_arch, lo_arch;

  int checks = 0;
  int failures = 0;

  hilo_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_hi_write (ex_hi_write),
    .ex_lo_write (ex_lo_write),
    .ex_hi_data  (ex_hi_data),
    .ex_lo_data  (ex_lo_data),
    .hi_rd       (hi_rd),
    .lo_rd       (lo_rd),
    .hi_arch     (hi_arch),
    .lo_arch     (lo_arch)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each accepted write waits a number of advancing edges before commit.
  typedef struct {
    logic        hw;
    logic        lw;
    logic [31:0] hd;
    logic [31:0] ld;
    int          edges_left;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic model_reset();
    pend.delete();
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic model_commit(input pend_t p);
    if (p.hw) m_hi = p.hd;
    if (p.lw) m_lo = p.ld;
  endtask

  task automatic model_edge();
    pend_t keep[$];
    pend_t n;
    if (flush) begin
      foreach (pend[i]) if (pend[i].edges_left == 1) model_commit(pend[i]);
      pend.delete();
    end else if (!stall) begin
      foreach (pend[i]) begin
        if (pend[i].edges_left == 1) model_commit(pend[i]);
        else begin
          n = pend[i];
          n.edges_left = n.edges_left - 1;
          keep.push_back(n);
        end
      end
      pend = keep;
      if (ex_valid && (ex_hi_write || ex_lo_write)) begin
        n.hw = ex_hi_write;
        n.lw = ex_lo_write;
        n.hd = ex_hi_data;
        n.ld = ex_lo_data;
        n.edges_left = 2;
        pend.push_back(n);
      end
    end
  endtask

  function automatic logic [31:0] model_hi_rd();
    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].hw) return pend[i].hd;
    return m_hi;
  endfunction

  function automatic logic [31:0] model_lo_rd();
    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].lw) return pend[i].ld;
    return m_lo;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic hw,
                       input logic lw, input logic [31:0] hd, input logic [31:0] ld);
    stall = st; flush = fl; ex_valid = v; ex_hi_write = hw; ex_lo_write = lw;
    ex_hi_data = hd; ex_lo_data = ld;
  endtask

  // One clock edge: model follows the inputs the DUT sampled, then settle.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        st, fl, v, hw, lw;
    logic [31:0] hd, ld;
    logic [31:0] e_hrd, e_lrd, e_harch, e_larch;
  } vec_t;

  vec_t vt[$];

  task automatic addv(input logic st, input logic fl, input logic v, input logic hw, input logic lw,
                      input logic [31:0] hd, input logic [31:0] ld,
                      input logic [31:0] ehr, input logic [31:0] elr,
                      input logic [31:0] eha, input logic [31:0] ela);
    vec_t x;
    x.st = st; x.fl = fl; x.v = v; x.hw = hw; x.lw = lw; x.hd = hd; x.ld = ld;
    x.e_hrd = ehr; x.e_lrd = elr; x.e_harch = eha; x.e_larch = ela;
    vt.push_back(x);
  endtask

  initial begin
    // MULT write hi=1 lo=FFFFFFFE
    addv(0,0,1,1,1, 32'h1, 32'hFFFFFFFE,  32'h1, 32'hFFFFFFFE, 32'h0, 32'h0);
    addv(0,0,0,0,0, 32'h0, 32'h0,         32'h1, 32'hFFFFFFFE, 32'h0, 32'h0);
    addv(0,0,0,0,0, 32'h0, 32'h0,         32'h1, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE);
    // Split sources: MTLO 0x11 then MTHI 0x22
    addv(0,0,1,0,1, 32'hDEAD, 32'h11,     32'h1, 32'h11, 32'h1, 32'hFFFFFFFE);
    addv(0,0,1,1,0, 32'h22, 32'hBEEF,     32'h22, 32'h11, 32'h1, 32'hFFFFFFFE);
    addv(0,0,0,1,1, 32'h5, 32'h6,         32'h22, 32'h11, 32'h1, 32'h11);
    addv(0,0,0,0,0, 32'h0, 32'h0,         32'h22, 32'h11, 32'h22, 32'h11);
    // Stall: capture 0x33, stall 3 cycles with a dropped EX write
    addv(0,0,1,1,0, 32'h33, 32'h0,        32'h33, 32'h11, 32'h22, 32'h11);
    addv(1,0,1,1,1, 32'h99, 32'h98,       32'h33, 32'h11, 32'h22, 32'h11);
    addv(1,0,1,1,1, 32'h99, 32'h98,       32'h33, 32'h11, 32'h22, 32'h11);
    addv(1,0,1,1,1, 32'h99, 32'h98,       32'h33, 32'h11, 32'h22, 32'h11);
    addv(0,0,0,0,0, 32'h0, 32'h0,         32'h33, 32'h11, 32'h22, 32'h11);
    // Stall while W holds a write: commit deferred
    addv(1,0,0,0,0, 32'h0, 32'h0,         32'h33, 32'h11, 32'h22, 32'h11);
    addv(0,0,0,0,0, 32'h0, 32'h0,         32'h33, 32'h11, 32'h33, 32'h11);
    addv(0,0,0,0,0, 32'h0, 32'h0,         32'h33, 32'h11, 32'h33, 32'h11);
    // Flush: W=AA, M=BB
    addv(0,0,1,1,0, 32'hAA, 32'h0,        32'hAA, 32'h11, 32'h33, 32'h11);
    addv(0,0,1,1,0, 32'hBB, 32'h0,        32'hBB, 32'h11, 32'h33, 32'h11);
    addv(0,1,1,1,0, 32'hDD, 32'h0,        32'hAA, 32'h11, 32'hAA, 32'h11);
    addv(0,0,0,0,0, 32'h0, 32'h0,         32'hAA, 32'h11, 32'hAA, 32'h11);
    addv(0,0,0,0,0, 32'h0, 32'h0,         32'hAA, 32'h11, 32'hAA, 32'h11);
    // Flush during stall with EX write 0xCC
    addv(0,0,1,1,0, 32'h44, 32'h0,        32'h44, 32'h11, 32'hAA, 32'h11);
    addv(0,0,1,0,1, 32'h0, 32'h55,        32'h44, 32'h55, 32'hAA, 32'h11);
    addv(1,1,1,1,1, 32'hCC, 32'hCC,       32'h44, 32'h11, 32'h44, 32'h11);
    addv(0,0,0,0,0, 32'h0, 32'h0,         32'h44, 32'h11, 32'h44, 32'h11);
  end

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    #1;
    check("reset_hi_rd", hi_rd, 32'h0);
    check("reset_lo_rd", lo_rd, 32'h0);
    check("reset_hi_arch", hi_arch, 32'h0);
    check("reset_lo_arch", lo_arch, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_hi_rd", hi_rd, 32'h0);
      check("idle_lo_arch", lo_arch, 32'h0);
    end

    // Directed table
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].st, vt[i].fl, vt[i].v, vt[i].hw, vt[i].lw, vt[i].hd, vt[i].ld);
      tick();
      check($sformatf("vec%0d_hi_rd", i), hi_rd, vt[i].e_hrd);
      check($sformatf("vec%0d_lo_rd", i), lo_rd, vt[i].e_lrd);
      check($sformatf("vec%0d_hi_arch", i), hi_arch, vt[i].e_harch);
      check($sformatf("vec%0d_lo_arch", i), lo_arch, vt[i].e_larch);
    end

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
            1'($urandom), 1'($urandom), $urandom, $urandom);
      tick();
      check("rnd_hi_rd", hi_rd, model_hi_rd());
      check("rnd_lo_rd", lo_rd, model_lo_rd());
      check("rnd_hi_arch", hi_arch, m_hi);
      check("rnd_lo_arch", lo_arch, m_lo);
    end

    // Asynchronous reset mid-cycle with writes in flight
    drive(0, 0, 1, 1, 1, 32'h1234, 32'h5678);
    tick();
    drive(0, 0, 1, 1, 1, 32'h9ABC, 32'hDEF0);
    tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_hi_rd", hi_rd, 32'h0);
    check("async_rst_lo_rd", lo_rd, 32'h0);
    check("async_rst_hi_arch", hi_arch, 32'h0);
    check("async_rst_lo_arch", lo_arch, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_hi_rd", hi_rd, 32'h0);
      check("post_rst_lo_rd", lo_rd, 32'h0);
      check("post_rst_hi_arch", hi_arch, 32'h0);
      check("post_rst_lo_arch", lo_arch, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
